// File: rtl/cube_pkg.sv
// Shared types and constants for the cube edge sequencer: state encoding,
// vertex/coordinate widths and the fixed 12-edge wireframe table.
package cube_pkg;

   localparam int X_W    = 11;
   localparam int Y_W    = 10;
   localparam int N_VTX  = 8;
   localparam int N_EDGE = 12;
   localparam int VA_W   = 3;
   localparam int EI_W   = 4;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      ISSUE,
      NEXT
   } state_e;

   // Each entry packs {vertex a, vertex b}; octal keeps the pairs readable.
   localparam logic [5:0] EDGE_TBL [N_EDGE] = '{
      6'o01, 6'o12, 6'o23, 6'o30,
      6'o45, 6'o56, 6'o67, 6'o74,
      6'o04, 6'o15, 6'o26, 6'o37
   };

   function automatic logic [VA_W-1:0] edge_a(input logic [EI_W-1:0] idx);
      logic [5:0] pair;
      pair = EDGE_TBL[idx];
      return pair[5:3];
   endfunction

   function automatic logic [VA_W-1:0] edge_b(input logic [EI_W-1:0] idx);
      logic [5:0] pair;
      pair = EDGE_TBL[idx];
      return pair[2:0];
   endfunction

endpackage

// File: rtl/cube_vertex_rf.sv
// Eight-entry projected-vertex store: one synchronous write port and two
// combinational read ports feeding the edge endpoint registers.
module cube_vertex_rf
   import cube_pkg::*;
(
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            we_i,
   input  logic [VA_W-1:0] waddr_i,
   input  logic [X_W-1:0]  wx_i,
   input  logic [Y_W-1:0]  wy_i,
   input  logic [VA_W-1:0] raddr_a_i,
   input  logic [VA_W-1:0] raddr_b_i,
   output logic [X_W-1:0]  x_a_o,
   output logic [Y_W-1:0]  y_a_o,
   output logic [X_W-1:0]  x_b_o,
   output logic [Y_W-1:0]  y_b_o
);

   logic [X_W-1:0] x_q [N_VTX];
   logic [Y_W-1:0] y_q [N_VTX];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < N_VTX; i++) begin
            x_q[i] <= '0;
            y_q[i] <= '0;
         end
      end else if (we_i) begin
         x_q[waddr_i] <= wx_i;
         y_q[waddr_i] <= wy_i;
      end
   end

   assign x_a_o = x_q[raddr_a_i];
   assign y_a_o = y_q[raddr_a_i];
   assign x_b_o = x_q[raddr_b_i];
   assign y_b_o = y_q[raddr_b_i];

endmodule

// File: rtl/cube_edge_sequencer.sv
// Walks the 12 cube edges, presenting stable endpoints to the line engine
// with a frame-count watchdog. Define CUBE_SEQ_AUTOLOOP_EN to loop passes forever.
//
// state | meaning
// IDLE  | waiting for go
// LOAD  | copy endpoints of edge_idx from the vertex store, clear frame count
// ISSUE | endpoints valid; wait for line_done or watchdog expiry
// NEXT  | advance edge_idx, or end the pass after edge 11
module cube_edge_sequencer
   import cube_pkg::*;
#(
   parameter int TIMEOUT_FRAMES = 4
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            vtx_we_i,
   input  logic [VA_W-1:0] vtx_addr_i,
   input  logic [X_W-1:0]  vtx_x_i,
   input  logic [Y_W-1:0]  vtx_y_i,
   input  logic            go_i,
   input  logic            frame_sync_i,
   input  logic            line_done_i,
   output logic [X_W-1:0]  x0_o,
   output logic [Y_W-1:0]  y0_o,
   output logic [X_W-1:0]  x1_o,
   output logic [Y_W-1:0]  y1_o,
   output logic            line_valid_o,
   output logic [EI_W-1:0] edge_idx_o,
   output logic            busy_o,
   output logic            pass_done_o,
   output logic            timeout_err_o
);

   localparam int CNT_W = (TIMEOUT_FRAMES > 7) ? $clog2(TIMEOUT_FRAMES + 1) : 3;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_FRAMES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [EI_W-1:0]  IDX_LAST = EI_W'(N_EDGE - 1);

   state_e          state_q, state_d;
   logic [EI_W-1:0] idx_q, idx_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [X_W-1:0]  x0_q, x0_d, x1_q, x1_d;
   logic [Y_W-1:0]  y0_q, y0_d, y1_q, y1_d;
   logic            terr_q, terr_d;
   logic            pdone_q, pdone_d;

   logic [X_W-1:0]  rf_xa, rf_xb;
   logic [Y_W-1:0]  rf_ya, rf_yb;

   cube_vertex_rf u_rf (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .we_i      (vtx_we_i),
      .waddr_i   (vtx_addr_i),
      .wx_i      (vtx_x_i),
      .wy_i      (vtx_y_i),
      .raddr_a_i (edge_a(idx_q)),
      .raddr_b_i (edge_b(idx_q)),
      .x_a_o     (rf_xa),
      .y_a_o     (rf_ya),
      .x_b_o     (rf_xb),
      .y_b_o     (rf_yb)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      x0_d    = x0_q;
      y0_d    = y0_q;
      x1_d    = x1_q;
      y1_d    = y1_q;
      terr_d  = terr_q;
      pdone_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (go_i) begin
               state_d = LOAD;
               idx_d   = '0;
               terr_d  = 1'b0;
            end
         end
         LOAD: begin
            x0_d    = rf_xa;
            y0_d    = rf_ya;
            x1_d    = rf_xb;
            y1_d    = rf_yb;
            cnt_d   = '0;
            state_d = ISSUE;
         end
         ISSUE: begin
            // A completion wins over a watchdog expiry in the same cycle.
            if (line_done_i) begin
               state_d = NEXT;
            end else if (frame_sync_i) begin
               if (cnt_q == CNT_LAST) begin
                  terr_d  = 1'b1;
                  state_d = NEXT;
               end else if (cnt_q != CNT_MAX) begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         NEXT: begin
            if (idx_q == IDX_LAST) begin
               pdone_d = 1'b1;
`ifdef CUBE_SEQ_AUTOLOOP_EN
               idx_d   = '0;
               state_d = LOAD;
`else
               state_d = IDLE;
`endif
            end else begin
               idx_d   = idx_q + 1'b1;
               state_d = LOAD;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         x0_q    <= '0;
         y0_q    <= '0;
         x1_q    <= '0;
         y1_q    <= '0;
         terr_q  <= 1'b0;
         pdone_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         x0_q    <= x0_d;
         y0_q    <= y0_d;
         x1_q    <= x1_d;
         y1_q    <= y1_d;
         terr_q  <= terr_d;
         pdone_q <= pdone_d;
      end
   end

   assign x0_o          = x0_q;
   assign y0_o          = y0_q;
   assign x1_o          = x1_q;
   assign y1_o          = y1_q;
   assign line_valid_o  = (state_q == ISSUE);
   assign edge_idx_o    = idx_q;
   assign busy_o        = (state_q != IDLE);
   assign pass_done_o   = pdone_q;
   assign timeout_err_o = terr_q;

endmodule

// File: tb/tb_cube_edge_sequencer.sv
// Scoreboard bench for cube_edge_sequencer: stimulus pushes expected edge and
// pass records; a negedge monitor pops and compares on each issue or pass_done.
module tb_cube_edge_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        vtx_we = 1'b0;
   logic [2:0]  vtx_addr = '0;
   logic [10:0] vtx_x = '0;
   logic [9:0]  vtx_y = '0;
   logic        go = 1'b0;
   logic        frame_sync = 1'b0;
   logic        line_done = 1'b0;
   logic [10:0] x0, x1;
   logic [9:0]  y0, y1;
   logic        line_valid;
   logic [3:0]  edge_idx;
   logic        busy, pass_done, timeout_err;

   always #5 clk = ~clk;

   cube_edge_sequencer #(.TIMEOUT_FRAMES(4)) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .vtx_we_i      (vtx_we),
      .vtx_addr_i    (vtx_addr),
      .vtx_x_i       (vtx_x),
      .vtx_y_i       (vtx_y),
      .go_i          (go),
      .frame_sync_i  (frame_sync),
      .line_done_i   (line_done),
      .x0_o          (x0),
      .y0_o          (y0),
      .x1_o          (x1),
      .y1_o          (y1),
      .line_valid_o  (line_valid),
      .edge_idx_o    (edge_idx),
      .busy_o        (busy),
      .pass_done_o   (pass_done),
      .timeout_err_o (timeout_err)
   );

   typedef struct packed {
      logic        is_pass;
      logic [3:0]  idx;
      logic [10:0] x0;
      logic [9:0]  y0;
      logic [10:0] x1;
      logic [9:0]  y1;
      logic        terr;
      logic        busy;
   } rec_t;

   rec_t        exp_q[$];
   int          total = 0;
   int          bad = 0;
   int          ea [12] = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1, 2, 3};
   int          eb [12] = '{1, 2, 3, 0, 5, 6, 7, 4, 4, 5, 6, 7};
   logic [10:0] mx [8];
   logic [9:0]  my [8];
   logic        exp_terr = 1'b0;
   logic        prev_lv = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   function automatic rec_t edge_rec(input int e);
      rec_t r;
      r.is_pass = 1'b0;
      r.idx     = e[3:0];
      r.x0      = mx[ea[e]];
      r.y0      = my[ea[e]];
      r.x1      = mx[eb[e]];
      r.y1      = my[eb[e]];
      r.terr    = exp_terr;
      r.busy    = 1'b1;
      return r;
   endfunction

   function automatic rec_t pass_rec(input logic bsy);
      rec_t r;
      r         = '0;
      r.is_pass = 1'b1;
      r.terr    = exp_terr;
      r.busy    = bsy;
      return r;
   endfunction

   task automatic sb_pop(input string nm, input rec_t act);
      if (exp_q.size() == 0) begin
         total++;
         bad++;
         $display("FAIL %s: unexpected output got %h want none", nm, act);
      end else begin
         chk(nm, 64'(act), 64'(exp_q.pop_front()));
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (line_valid && !prev_lv)
            sb_pop("edge_issue", {1'b0, edge_idx, x0, y0, x1, y1, timeout_err, busy});
         if (pass_done)
            sb_pop("pass_done", {1'b1, 4'd0, 11'd0, 10'd0, 11'd0, 10'd0, timeout_err, busy});
         prev_lv = line_valid;
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse(input logic g, input logic d, input logic f);
      tick();
      go = g; line_done = d; frame_sync = f;
      tick();
      go = 1'b0; line_done = 1'b0; frame_sync = 1'b0;
   endtask

   task automatic write_vtx(input int a, input int x, input int y);
      tick();
      vtx_we = 1'b1; vtx_addr = a[2:0]; vtx_x = x[10:0]; vtx_y = y[9:0];
      tick();
      vtx_we = 1'b0;
      mx[a] = x[10:0];
      my[a] = y[9:0];
   endtask

   task automatic wait_valid(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (line_valid) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      if (!ok) begin
         total++;
         bad++;
         $display("FAIL wait_valid: got line_valid=0 want 1 within 40 cycles");
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      exp_q.delete();
      for (int i = 0; i < 8; i++) begin
         mx[i] = '0;
         my[i] = '0;
      end
      exp_terr = 1'b0;
   endtask

   task automatic run_pass(input int to_edge, input int slow_edge, input int tie_edge,
                           input bit wr_mid, input int go_edge, input int rst_edge);
      bit ok;
      logic [10:0] old_x1;
      exp_terr = 1'b0;
      exp_q.push_back(edge_rec(0));
      pulse(1'b1, 1'b0, 1'b0);
      chk("busy_after_go", busy, 1);
      chk("lv_after_go", line_valid, 0);
      for (int e = 0; e < 12; e++) begin
         wait_valid(ok);
         if (!ok) return;
         if (wr_mid && e == 0) begin
            old_x1 = mx[1];
            write_vtx(1, 500, 60);
            chk("x1_held", x1, old_x1);
         end
         if (e == go_edge) begin
            pulse(1'b1, 1'b0, 1'b0);
            chk("go_ignored_idx", edge_idx, e);
            chk("go_ignored_lv", line_valid, 1);
         end
         if (e == rst_edge) begin
            tick();
            do_reset();
            #1;
            chk("rst_outputs", {x0, y0, x1, y1, line_valid, edge_idx, busy, pass_done, timeout_err}, 0);
            tick(2);
            rst_n = 1'b1;
            tick();
            return;
         end
         tick(5);
         if (e == to_edge) begin
            repeat (3) begin pulse(1'b0, 1'b0, 1'b1); tick(2); end
            exp_terr = 1'b1;
            exp_q.push_back(edge_rec(e + 1));
            pulse(1'b0, 1'b0, 1'b1);
            tick(2);
            chk("timeout_idx", edge_idx, e + 1);
            chk("timeout_err_set", timeout_err, 1);
            continue;
         end
         if (e == slow_edge || e == tie_edge)
            repeat (3) begin pulse(1'b0, 1'b0, 1'b1); tick(2); end
         if (e < 11) begin
            exp_q.push_back(edge_rec(e + 1));
         end else begin
`ifdef CUBE_SEQ_AUTOLOOP_EN
            exp_q.push_back(pass_rec(1'b1));
            exp_q.push_back(edge_rec(0));
`else
            exp_q.push_back(pass_rec(1'b0));
`endif
         end
         pulse(1'b0, 1'b1, e == tie_edge);
      end
`ifdef CUBE_SEQ_AUTOLOOP_EN
      tick(2);
      chk("loop_idx", edge_idx, 0);
      chk("loop_lv", line_valid, 1);
      chk("loop_busy", busy, 1);
`else
      tick(3);
      chk("busy_end", busy, 0);
      chk("terr_end", timeout_err, exp_terr);
`endif
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got no finish want finish before 300us");
      $fatal(1, "bench timeout");
   end

   initial begin
      do_reset();
      tick(2);
      chk("rst_endpoints", {x0, y0, x1, y1}, 0);
      chk("rst_lv_idx", {line_valid, edge_idx}, 0);
      chk("rst_flags", {busy, pass_done, timeout_err}, 0);
      rst_n = 1'b1;
      tick();
      write_vtx(0, 100, 50);
      write_vtx(1, 300, 50);
      write_vtx(2, 300, 250);
      write_vtx(3, 100, 250);
      write_vtx(4, 150, 100);
      write_vtx(5, 350, 100);
      write_vtx(6, 1279, 799);
      write_vtx(7, 150, 300);
`ifdef CUBE_SEQ_AUTOLOOP_EN
      run_pass(-1, -1, -1, 1'b0, -1, -1);
      tick(2);
      do_reset();
      tick(2);
      rst_n = 1'b1;
`else
      run_pass(-1, 5, 7, 1'b0, -1, -1);
      run_pass(3, -1, -1, 1'b1, -1, -1);
      run_pass(-1, -1, -1, 1'b0, 2, 4);
      run_pass(-1, -1, -1, 1'b0, -1, -1);
`endif
      tick(5);
      chk("sb_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
